// File: rtl/alu_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_mdu_pkg
// Description : Shared alu_defs: opcode encodings for the integer execution
//               unit (ALU, branch compare, RV32M) and the FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_mdu_pkg;

    localparam int c_OPCODE_WIDTH = 5;

    // Existing ALU encoding (1..15)
    localparam int c_OP_AND    = 1;
    localparam int c_OP_OR     = 2;
    localparam int c_OP_XOR    = 3;
    localparam int c_OP_ADD    = 4;
    localparam int c_OP_SUB    = 5;
    localparam int c_OP_SRL    = 6;
    localparam int c_OP_SRA    = 7;
    localparam int c_OP_SLL    = 8;
    localparam int c_OP_LT     = 9;
    localparam int c_OP_LTU    = 10;
    localparam int c_OP_EQ     = 11;
    localparam int c_OP_NE     = 12;
    localparam int c_OP_GE     = 13;
    localparam int c_OP_GEU    = 14;
    localparam int c_OP_JALR   = 15;

    // RV32M group (16..23)
    localparam int c_OP_MUL    = 16;
    localparam int c_OP_MULH   = 17;
    localparam int c_OP_MULHSU = 18;
    localparam int c_OP_MULHU  = 19;
    localparam int c_OP_DIV    = 20;
    localparam int c_OP_DIVU   = 21;
    localparam int c_OP_REM    = 22;
    localparam int c_OP_REMU   = 23;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_DIV  = 1'b1
    } state_t;

endpackage : alu_mdu_pkg
`default_nettype wire

// File: rtl/alu_mdu_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_mdu_div_iter
// Description : Iterative radix-2 restoring unsigned divider. One quotient
//               bit per enabled edge; quotient/remainder ports present the
//               values produced by the step taken on the coming edge so the
//               owner can capture the final result on the last step.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mdu_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            en,
    input  logic            abort,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            last,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int c_CW = $clog2(XLEN + 1);

    logic [c_CW-1:0] r_count;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_dvs;

    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_fits;

    // Partial remainder shifted left by one with the next dividend bit.
    // The running remainder is always below the divisor, so a carry out of
    // XLEN bits can only happen when the trial subtraction succeeds.
    assign w_shift   = {r_rem, r_quo[XLEN-1]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_fits    = ~w_diff[XLEN];
    assign quotient  = {r_quo[XLEN-2:0], w_fits};
    assign remainder = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign busy      = (r_count != '0);
    assign last      = (r_count == c_CW'(1));

    // Load on start, step while busy, drop the operation on abort.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_count <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
        end else if (en) begin
            if (abort) begin
                r_count <= '0;
            end else if (start) begin
                r_count <= c_CW'(XLEN);
                r_quo   <= dividend;
                r_rem   <= '0;
                r_dvs   <= divisor;
            end else if (busy) begin
                r_count <= r_count - c_CW'(1);
                r_quo   <= quotient;
                r_rem   <= remainder;
            end
        end
    end

endmodule : alu_mdu_div_iter
`default_nettype wire

// File: rtl/alu_mdu.sv
`default_nettype none
// ============================================================================
// Module      : alu_mdu
// Description : Integer execution unit: RV32I ALU/compare ops and RV32M
//               multiply (single cycle) and divide (iterative, with
//               ready/busy handshake). One tagged result per operation.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int ROB_WIDTH    = 4,
    parameter int OPCODE_WIDTH = c_OPCODE_WIDTH
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    clear_signal,
    input  logic                    cal_signal,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [XLEN-1:0]         lhs,
    input  logic [XLEN-1:0]         rhs,
    input  logic [ROB_WIDTH-1:0]    tag,
    output logic                    ready_out,
    output logic                    done_out,
    output logic [XLEN-1:0]         result_out,
    output logic [ROB_WIDTH-1:0]    tag_out
);

    localparam int c_SHW = $clog2(XLEN);

    state_t               r_state;
    logic                 r_done;
    logic [XLEN-1:0]      r_result;
    logic [ROB_WIDTH-1:0] r_tag;
    logic [ROB_WIDTH-1:0] r_div_tag;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_sel_rem;

    logic [c_SHW-1:0]     w_shamt;
    logic                 w_is_div;
    logic                 w_is_rem;
    logic                 w_signed_div;
    logic                 w_div_zero;
    logic                 w_div_ovf;
    logic                 w_special;
    logic [XLEN-1:0]      w_special_res;
    logic                 w_lhs_neg;
    logic                 w_rhs_neg;
    logic [XLEN-1:0]      w_lhs_mag;
    logic [XLEN-1:0]      w_rhs_mag;
    logic                 w_mul_lsgn;
    logic                 w_mul_rsgn;
    logic [XLEN:0]        w_mul_lext;
    logic [XLEN:0]        w_mul_rext;
    logic [2*XLEN-1:0]    w_mul_a;
    logic [2*XLEN-1:0]    w_mul_b;
    logic [2*XLEN-1:0]    w_prod;
    logic [XLEN-1:0]      w_fast;
    logic                 w_accept;
    logic                 w_div_start;
    logic                 w_div_busy;
    logic                 w_div_last;
    logic [XLEN-1:0]      w_div_quo;
    logic [XLEN-1:0]      w_div_rem;
    logic [XLEN-1:0]      w_div_res;

    assign w_shamt      = rhs[c_SHW-1:0];
    assign w_is_div     = (opcode >= OPCODE_WIDTH'(c_OP_DIV)) && (opcode <= OPCODE_WIDTH'(c_OP_REMU));
    assign w_is_rem     = (opcode == OPCODE_WIDTH'(c_OP_REM)) || (opcode == OPCODE_WIDTH'(c_OP_REMU));
    assign w_signed_div = (opcode == OPCODE_WIDTH'(c_OP_DIV)) || (opcode == OPCODE_WIDTH'(c_OP_REM));

    // Divide special cases resolve in one cycle without the iterative engine.
    assign w_div_zero    = (rhs == '0);
    assign w_div_ovf     = w_signed_div && (lhs == {1'b1, {(XLEN-1){1'b0}}}) && (rhs == '1);
    assign w_special     = w_div_zero || w_div_ovf;
    assign w_special_res = w_div_zero ? (w_is_rem ? lhs : '1)
                                      : (w_is_rem ? '0  : lhs);

    // Unsigned magnitudes for the engine; MIN maps onto itself, which is the
    // correct unsigned magnitude.
    assign w_lhs_neg = w_signed_div && lhs[XLEN-1];
    assign w_rhs_neg = w_signed_div && rhs[XLEN-1];
    assign w_lhs_mag = w_lhs_neg ? -lhs : lhs;
    assign w_rhs_mag = w_rhs_neg ? -rhs : rhs;

    // Multiplier: XLEN+1-bit sign/zero-extended operands, widened to 2*XLEN
    // so a single unsigned product yields the correct low 2*XLEN bits.
    assign w_mul_lsgn = (opcode == OPCODE_WIDTH'(c_OP_MULH)) || (opcode == OPCODE_WIDTH'(c_OP_MULHSU));
    assign w_mul_rsgn = (opcode == OPCODE_WIDTH'(c_OP_MULH));
    assign w_mul_lext = {w_mul_lsgn && lhs[XLEN-1], lhs};
    assign w_mul_rext = {w_mul_rsgn && rhs[XLEN-1], rhs};
    assign w_mul_a    = {{(XLEN-1){w_mul_lext[XLEN]}}, w_mul_lext};
    assign w_mul_b    = {{(XLEN-1){w_mul_rext[XLEN]}}, w_mul_rext};
    assign w_prod     = w_mul_a * w_mul_b;

    // Single-cycle result mux for everything except a normal divide.
    always_comb begin
        w_fast = '0;
        case (opcode)
            OPCODE_WIDTH'(c_OP_AND):    w_fast = lhs & rhs;
            OPCODE_WIDTH'(c_OP_OR):     w_fast = lhs | rhs;
            OPCODE_WIDTH'(c_OP_XOR):    w_fast = lhs ^ rhs;
            OPCODE_WIDTH'(c_OP_ADD):    w_fast = lhs + rhs;
            OPCODE_WIDTH'(c_OP_SUB):    w_fast = lhs - rhs;
            OPCODE_WIDTH'(c_OP_SRL):    w_fast = lhs >> w_shamt;
            OPCODE_WIDTH'(c_OP_SRA):    w_fast = $unsigned($signed(lhs) >>> w_shamt);
            OPCODE_WIDTH'(c_OP_SLL):    w_fast = lhs << w_shamt;
            OPCODE_WIDTH'(c_OP_LT):     w_fast = {XLEN{$signed(lhs) < $signed(rhs)}};
            OPCODE_WIDTH'(c_OP_LTU):    w_fast = {XLEN{lhs < rhs}};
            OPCODE_WIDTH'(c_OP_EQ):     w_fast = {XLEN{lhs == rhs}};
            OPCODE_WIDTH'(c_OP_NE):     w_fast = {XLEN{lhs != rhs}};
            OPCODE_WIDTH'(c_OP_GE):     w_fast = {XLEN{$signed(lhs) >= $signed(rhs)}};
            OPCODE_WIDTH'(c_OP_GEU):    w_fast = {XLEN{lhs >= rhs}};
            OPCODE_WIDTH'(c_OP_JALR):   w_fast = (lhs + rhs) & ~{{(XLEN-1){1'b0}}, 1'b1};
            OPCODE_WIDTH'(c_OP_MUL):    w_fast = w_prod[XLEN-1:0];
            OPCODE_WIDTH'(c_OP_MULH),
            OPCODE_WIDTH'(c_OP_MULHSU),
            OPCODE_WIDTH'(c_OP_MULHU):  w_fast = w_prod[2*XLEN-1:XLEN];
            OPCODE_WIDTH'(c_OP_DIV),
            OPCODE_WIDTH'(c_OP_DIVU),
            OPCODE_WIDTH'(c_OP_REM),
            OPCODE_WIDTH'(c_OP_REMU):   w_fast = w_special_res;
            default:                    w_fast = '0;
        endcase
    end

    assign ready_out   = (r_state == S_IDLE);
    assign w_accept    = rdy_in && !clear_signal && ready_out && cal_signal;
    assign w_div_start = w_accept && w_is_div && !w_special;

    alu_mdu_div_iter #(
        .XLEN (XLEN)
    ) u_div_iter (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .en        (rdy_in),
        .abort     (clear_signal),
        .start     (w_div_start),
        .dividend  (w_lhs_mag),
        .divisor   (w_rhs_mag),
        .busy      (w_div_busy),
        .last      (w_div_last),
        .quotient  (w_div_quo),
        .remainder (w_div_rem)
    );

    // Sign correction of the final step: quotient negative when operand
    // signs differ, remainder follows the dividend.
    assign w_div_res = r_sel_rem ? (r_neg_r ? -w_div_rem : w_div_rem)
                                 : (r_neg_q ? -w_div_quo : w_div_quo);

    // Control FSM with registered result bus; rdy_in low freezes everything.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state   <= S_IDLE;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_tag     <= '0;
            r_div_tag <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_sel_rem <= 1'b0;
        end else if (rdy_in) begin
            r_done <= 1'b0;
            if (clear_signal) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (cal_signal) begin
                            if (w_is_div && !w_special) begin
                                r_state   <= S_DIV;
                                r_div_tag <= tag;
                                r_neg_q   <= w_lhs_neg ^ w_rhs_neg;
                                r_neg_r   <= w_lhs_neg;
                                r_sel_rem <= w_is_rem;
                            end else begin
                                r_result <= w_fast;
                                r_tag    <= tag;
                                r_done   <= 1'b1;
                            end
                        end
                    end
                    S_DIV: begin
                        if (w_div_last) begin
                            r_result <= w_div_res;
                            r_tag    <= r_div_tag;
                            r_done   <= 1'b1;
                            r_state  <= S_IDLE;
                        end else if (!w_div_busy) begin
                            // Engine idle without a final step: recover.
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign done_out   = r_done;
    assign result_out = r_result;
    assign tag_out    = r_tag;

endmodule : alu_mdu
`default_nettype wire
